// File: rtl/mac_accumulator.sv
// Multiply-accumulate of len 4x4 beats; out_valid 2 cycles after last accept; in_ready only in ACCUM, sum held until out_ready.
// MAC_ACC_SATURATE_EN clamps the accumulator at all ones on overflow; default build wraps.
module mac_accumulator #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic [ACC_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [7:0]         r_p_q;
    logic               r_p_v;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;

    logic               w_accept;
    logic               w_open;
    logic               w_last;
    logic [7:0]         w_prod;
    logic [ACC_W:0]     w_add;
    logic [ACC_W-1:0]   w_acc_nxt;

    assign w_prod   = {4'b0000, a} * {4'b0000, b};
    assign w_accept = in_valid && in_ready;
    assign w_open   = (r_state == S_IDLE) && start;
    assign w_last   = w_accept && (r_cnt == LEN_W'(1));

    // One extra bit on the adder exposes the carry that marks overflow.
    assign w_add = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, r_p_q};

`ifdef MAC_ACC_SATURATE_EN
    assign w_acc_nxt = w_add[ACC_W] ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
    assign w_acc_nxt = w_add[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (len != '0) ? S_ACCUM : S_DONE;
            S_ACCUM: if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE:  busy      = 1'b0;
            S_ACCUM: in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: busy      = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_q <= '0;
            r_p_v <= 1'b0;
        end else begin
            r_p_v <= w_accept;
            if (w_accept) r_p_q <= w_prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_open) begin
            r_cnt <= len;
        end else if (w_accept) begin
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_open) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_p_v) begin
            r_acc <= w_acc_nxt;
            r_ovf <= r_ovf | w_add[ACC_W];
        end
    end

    assign sum = r_acc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator (ACC_W=10) with a sum-of-products reference model.
module tb_mac_accumulator;

    localparam int W    = 10;
    localparam int LW   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic [LW-1:0] len       = '0;
    logic          in_valid  = 1'b0;
    logic [3:0]    a         = '0;
    logic [3:0]    b         = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic          ovf;
    logic [W-1:0]  sum;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_total = 0;
    int m_beats = 0;
    int m_len   = 0;
    int m_last  = -100;
    int m_start = -100;
    int cyc     = 0;
    logic          prev_ov  = 1'b0;
    logic [W-1:0]  prev_sum = '0;

    mac_accumulator #(.ACC_W(W), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int fold(input int t);
`ifdef MAC_ACC_SATURATE_EN
        return (t > MAXV) ? MAXV : t;
`else
        return t % (MAXV + 1);
`endif
    endfunction

    // Compare process: every cycle, mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_sum", 32'(sum), 0);
            chk("rst_flags", {28'd0, out_valid, in_ready, busy, ovf}, 0);
            m_total = 0;
            m_beats = 0;
            m_len   = 0;
            prev_ov = 1'b0;
        end else begin
            if (start && !busy) begin
                m_total = 0;
                m_beats = 0;
                m_len   = int'(len);
                m_start = cyc;
            end
            if (in_valid && in_ready) begin
                m_total += int'(a) * int'(b);
                m_beats++;
                m_last = cyc;
            end
            chk("excl_rdy_ov", 32'(in_ready && out_valid), 0);
            chk("busy_cover", 32'((in_ready || out_valid) && !busy), 0);
            if (out_valid) begin
                chk("model_sum", 32'(sum), 32'(fold(m_total)));
                chk("model_ovf", 32'(ovf), 32'(m_total > MAXV));
                if (!prev_ov) begin
                    chk("model_beats", 32'(m_beats), 32'(m_len));
                    if (m_len == 0) chk("lat_len0", 32'(cyc - m_start), 1);
                    else            chk("lat_last", 32'(cyc - m_last), 2);
                end else begin
                    chk("hold_sum", 32'(sum), 32'(prev_sum));
                end
            end
            prev_ov  = out_valid;
            prev_sum = sum;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = l[LW-1:0];
        step();
        start = 1'b0;
    endtask

    task automatic beat(input int x, input int y);
        a        = x[3:0];
        b        = y[3:0];
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !in_ready; n++) step();
        chk("beat_accept", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        chk("por_sum", 32'(sum), 0);
        chk("por_busy", 32'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 3*5 + 15*15 + 0*9 = 240
        do_start(3);
        beat(3, 5);
        beat(15, 15);
        beat(0, 9);
        chk("t1_drain_rdy", 32'(in_ready), 0);
        chk("t1_drain_ov", 32'(out_valid), 0);
        chk("t1_drain_busy", 32'(busy), 1);
        step();
        chk("t1_ov", 32'(out_valid), 1);
        chk("t1_sum", 32'(sum), 240);
        chk("t1_ovf", 32'(ovf), 0);
        chk("t1_done_rdy", 32'(in_ready), 0);
        release_out();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_sum", 32'(sum), 240);

        // len=0 goes straight to DONE with a cleared sum
        start = 1'b1;
        len   = '0;
        chk("t2_idle_rdy", 32'(in_ready), 0);
        step();
        start = 1'b0;
        chk("t2_ov", 32'(out_valid), 1);
        chk("t2_sum", 32'(sum), 0);
        chk("t2_rdy", 32'(in_ready), 0);
        in_valid = 1'b1;
        a = 4'd5;
        b = 4'd5;
        step();
        step();
        in_valid = 1'b0;
        chk("t2_sum_ignored", 32'(sum), 0);
        release_out();
        chk("t2_idle", 32'(busy), 0);

        // gap between beats, then long hold with a stray start
        do_start(2);
        beat(4, 4);
        for (int i = 0; i < 3; i++) begin
            chk("t3_gap_rdy", 32'(in_ready), 1);
            step();
        end
        chk("t3_gap_sum", 32'(sum), 16);
        beat(2, 7);
        step();
        chk("t3_ov", 32'(out_valid), 1);
        chk("t3_sum", 32'(sum), 30);
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            len   = 4'd3;
            step();
            chk("t3_hold_ov", 32'(out_valid), 1);
            chk("t3_hold_sum", 32'(sum), 30);
        end
        start = 1'b0;
        release_out();
        chk("t3_idle_busy", 32'(busy), 0);
        chk("t3_idle_rdy", 32'(in_ready), 0);

        // 5 * 225 = 1125 overflows 10 bits
        do_start(5);
        for (int i = 0; i < 5; i++) beat(15, 15);
        step();
        chk("t4_ov", 32'(out_valid), 1);
`ifdef MAC_ACC_SATURATE_EN
        chk("t4_sum", 32'(sum), 1023);
`else
        chk("t4_sum", 32'(sum), 101);
`endif
        chk("t4_ovf", 32'(ovf), 1);
        release_out();

        // asynchronous reset mid-run, then a fresh run
        do_start(3);
        beat(1, 1);
        beat(1, 1);
        chk("t5_pre_sum", 32'(sum), 1);
        chk("t5_pre_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_sum", 32'(sum), 0);
        chk("t5_async_flags", {28'd0, out_valid, in_ready, busy, ovf}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_ov", 32'(out_valid), 0);
            chk("t5_idle", 32'(busy), 0);
            step();
        end
        do_start(1);
        beat(2, 3);
        step();
        chk("t5_ov", 32'(out_valid), 1);
        chk("t5_sum", 32'(sum), 6);
        chk("t5_ovf", 32'(ovf), 0);
        release_out();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
